serial_rx_fsm: RTL
==================

SERIAL_RX_FSM -- requirements
Module: serial_rx_fsm

Interface
REQ-001 Parameter DATA_WIDTH_BASE, default 5: word width is 2**DATA_WIDTH_BASE bits (32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on each serial input (min 2).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 sck_rx  in  1  serial bit clock from the transmitter, asynchronous to clk.
REQ-006 data_rx  in  1  serial data, MSB first, valid at sck_rx rising edge.
REQ-007 latch_rx  in  1  word-boundary strobe; rising edge commits the shifted word.
REQ-008 rx_data  out  2**DATA_WIDTH_BASE  last committed word.
REQ-009 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 frame_err  out  1  one-cycle pulse on framing error.
REQ-013 overrun  out  1  one-cycle pulse when a committed word is dropped.

Function
REQ-014 sck_rx, data_rx, latch_rx each pass through SYNC_STAGES flops, then a registered rising-edge detector; data_rx is sampled in the same cycle the sck_rx edge is detected.
REQ-015 States: IDLE, SHIFT, WAIT_LATCH.
REQ-016 IDLE: first sck edge loads bit into shift register LSB, bit_cnt=1, -> SHIFT.
REQ-017 SHIFT: each sck edge shifts left, inserts data at LSB, bit_cnt+1; at bit_cnt == 2**DATA_WIDTH_BASE (plus 1 parity bit when enabled) -> WAIT_LATCH.
REQ-018 WAIT_LATCH: latch edge commits word -> IDLE; further sck edge -> frame_err pulse, discard, -> IDLE.
REQ-019 Latch edge in IDLE or SHIFT -> frame_err pulse, discard partial word, -> IDLE.
REQ-020 Commit: rx_data loaded and rx_valid set on the cycle after latch edge detection (latch_rx pin to rx_valid = SYNC_STAGES+2 clk cycles).
REQ-021 Handshake: rx_valid && rx_ready clears rx_valid next cycle; rx_data held stable while rx_valid high.
REQ-022 Commit while rx_valid && !rx_ready: new word dropped, rx_data unchanged, overrun pulses one cycle.
REQ-023 Commit and rx_ready in same cycle with rx_valid high: new word loaded, rx_valid stays high, no overrun.
REQ-024 bit_cnt width DATA_WIDTH_BASE+1; never wraps (saturates by leaving SHIFT).

Reset
REQ-025 rst high: state IDLE, shift register, bit_cnt, synchronizers, rx_data = 0; rx_valid, busy, frame_err, overrun = 0.
REQ-026 rst mid-frame discards partial word; first sck edge after release starts a new word.

Configuration
REQ-027 Macro SERIAL_RX_PARITY_EN defined: one even-parity bit follows the data bits; on commit a mismatch pulses frame_err and the word is discarded.
REQ-028 Macro absent: no parity bit, no parity logic; frame_err only from REQ-018/019.

Structure
REQ-029 Package serial_pkg holds DATA_WIDTH_BASE default, rx state enum, parity helper function.
REQ-030 Sub-module serial_sync_edge: SYNC_STAGES synchronizer + rising-edge detector, instantiated per input.

Verification
REQ-031 Shift 32'h56D0_1953 MSB first, sck period 8 clk, then latch -> rx_valid high, rx_data = 32'h56D0_1953, frame_err 0.
REQ-032 Latch after 20 bits -> frame_err one pulse, rx_valid stays 0, next full word received correctly.
REQ-033 Two words, rx_ready held 0 -> first word retained, overrun one pulse on second commit.
REQ-034 rst asserted after 10 bits, then full word 32'hFFFF_0000 -> rx_data = 32'hFFFF_0000, no frame_err.
REQ-035 SERIAL_RX_PARITY_EN: 32'h56D0_1953 with parity 0 -> accepted; parity 1 -> frame_err, rx_valid 0.
REQ-036 33rd sck edge in WAIT_LATCH (parity off) -> frame_err pulse, state IDLE, busy 0.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared word-size default, receiver state encoding and parity helper.
package serial_pkg;
    localparam int DATA_WIDTH_BASE = 5;
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LATCH} rx_state_t;
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/serial_rx_fsm_if.sv
// serial_rx_fsm_if: serial pins from the transmitter plus the word-level handshake to the consumer.
interface serial_rx_fsm_if import serial_pkg::*; #(parameter int DATA_WIDTH_BASE = serial_pkg::DATA_WIDTH_BASE);
    logic                            sck_rx;
    logic                            data_rx;
    logic                            latch_rx;
    logic [2**DATA_WIDTH_BASE-1:0]   rx_data;
    logic                            rx_valid;
    logic                            rx_ready;
    logic                            busy;
    logic                            frame_err;
    logic                            overrun;
    modport slave (
        input  sck_rx, data_rx, latch_rx, rx_ready,
        output rx_data, rx_valid, busy, frame_err, overrun
    );
    modport master (
        output sck_rx, data_rx, latch_rx, rx_ready,
        input  rx_data, rx_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_sync_edge.sv
// serial_sync_edge: multi-flop synchronizer followed by a registered rising-edge detector.
module serial_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic EDGE        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end
    // r_prev lines up in time with r_rise, so a level output samples data with the detected edge
    assign o_q = EDGE ? r_rise : r_prev;
endmodule

// File: rtl/serial_rx_fsm.sv
// serial_rx_fsm: MSB-first serial word receiver with latch strobe and valid/ready output.
// SERIAL_RX_PARITY_EN adds a trailing even-parity bit checked on commit.
module serial_rx_fsm import serial_pkg::*; #(
    parameter int DATA_WIDTH_BASE = serial_pkg::DATA_WIDTH_BASE,
    parameter int SYNC_STAGES     = 2
) (
    input  logic            clk,
    input  logic            rst,
    serial_rx_fsm_if.slave  bus
);
    localparam int W  = 2**DATA_WIDTH_BASE;
    localparam int CW = DATA_WIDTH_BASE + 1;
`ifdef SERIAL_RX_PARITY_EN
    localparam int BITS = W + 1;
`else
    localparam int BITS = W;
`endif
    logic          w_sck, w_data, w_latch;
    rx_state_t     r_state, w_state_nx;
    logic [W-1:0]  r_shift, w_shift_nx, r_rx_data;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          w_commit, w_ferr, r_rx_valid, r_ferr, r_ovr;
`ifdef SERIAL_RX_PARITY_EN
    logic          r_par, w_par_nx;
`endif
    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sck   (.clk(clk), .rst(rst), .i_d(bus.sck_rx),   .o_q(w_sck));
    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_data  (.clk(clk), .rst(rst), .i_d(bus.data_rx),  .o_q(w_data));
    serial_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_latch (.clk(clk), .rst(rst), .i_d(bus.latch_rx), .o_q(w_latch));
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_commit   = 1'b0;
        w_ferr     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            IDLE: begin
                if (w_latch) begin
                    w_ferr = 1'b1;
                end else if (w_sck) begin
                    w_shift_nx = {{(W-1){1'b0}}, w_data};
                    w_cnt_nx   = CW'(1);
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (w_latch) begin
                    w_ferr     = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end else if (w_sck) begin
                    w_cnt_nx = r_cnt + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    if (r_cnt == CW'(W)) w_par_nx = w_data; else
`endif
                    w_shift_nx = {r_shift[W-2:0], w_data};
                    if (w_cnt_nx == CW'(BITS)) w_state_nx = WAIT_LATCH;
                end
            end
            WAIT_LATCH: begin
                if (w_latch) begin
`ifdef SERIAL_RX_PARITY_EN
                    w_commit = even_parity(64'(r_shift)) == r_par;
                    w_ferr   = !w_commit;
`else
                    w_commit = 1'b1;
`endif
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end else if (w_sck) begin
                    w_ferr     = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_cnt      <= w_cnt_nx;
            r_ferr     <= w_ferr;
            // a pending unconsumed word wins over a new commit unless it is taken this cycle
            r_ovr      <= w_commit && r_rx_valid && !bus.rx_ready;
            r_rx_valid <= w_commit || (r_rx_valid && !bus.rx_ready);
            if (w_commit && !(r_rx_valid && !bus.rx_ready)) r_rx_data <= r_shift;
`ifdef SERIAL_RX_PARITY_EN
            r_par      <= w_par_nx;
`endif
        end
    end
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = r_state != IDLE;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
endmodule
